// File: rtl/regfile_sb.sv
// regfile_sb: multi-read, dual-write register file with write bypass and a pending-write scoreboard.
// Revision: 1.0
`default_nettype none

module regfile_sb #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*DW-1:0] rd,
  output logic [NR-1:0]    rrdy,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [DW-1:0]    wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [DW-1:0]    wd1,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_reg,
  output logic             busy_any
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] busy;

  logic wr0_ok, wr1_ok, iss_ok;
  assign wr0_ok = we0 && (wa0 != '0);
  assign wr1_ok = we1 && (wa1 != '0);
  assign iss_ok = iss_en && (iss_reg != '0);

  // Statement order sets priority: port 1 data over port 0, issue set over write clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr0_ok) begin
        mem[wa0]  <= wd0;
        busy[wa0] <= 1'b0;
      end
      if (wr1_ok) begin
        mem[wa1]  <= wd1;
        busy[wa1] <= 1'b0;
      end
      if (iss_ok) begin
        busy[iss_reg] <= 1'b1;
      end
    end
  end

  // Entry 0 is never set, so the OR covers only real registers.
  assign busy_any = |busy;

  generate
    for (genvar k = 0; k < NR; k++) begin : g_rd
      logic [AW-1:0] addr;
      logic          hit0, hit1;
      assign addr = ra[k*AW +: AW];
      assign hit0 = we0 && (wa0 == addr);
      assign hit1 = we1 && (wa1 == addr);

      always_comb begin
        rd[k*DW +: DW] = mem[addr];
        rrdy[k]        = 1'b1;
        if (addr == '0) begin
          rd[k*DW +: DW] = '0;
        end else begin
          if (hit1) begin
            rd[k*DW +: DW] = wd1;
          end else if (hit0) begin
            rd[k*DW +: DW] = wd0;
          end
          rrdy[k] = !busy[addr] || hit0 || hit1;
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed plus randomized checks of regfile_sb against an array-based reference model.
// Revision: 1.0
`default_nettype none

module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int DEPTH = 1 << AW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR*AW-1:0] ra = '0;
  logic [NR*DW-1:0] rd;
  logic [NR-1:0]    rrdy;
  logic             we0 = 1'b0, we1 = 1'b0, iss_en = 1'b0;
  logic [AW-1:0]    wa0 = '0, wa1 = '0, iss_reg = '0;
  logic [DW-1:0]    wd0 = '0, wd1 = '0;
  logic             busy_any;

  regfile_sb #(.DW(DW), .AW(AW), .NR(NR)) dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rrdy(rrdy),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_en(iss_en), .iss_reg(iss_reg), .busy_any(busy_any)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy [DEPTH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return m_mem[a];
  endfunction

  function automatic bit exp_rrdy(input logic [AW-1:0] a);
    return (a == 0) || !m_busy[a] || (we0 && wa0 == a) || (we1 && wa1 == a);
  endfunction

  function automatic bit exp_busy_any();
    for (int i = 0; i < DEPTH; i++) if (m_busy[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_all();
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("rd%0d", k), rd[k*DW +: DW], exp_rd(ra[k*AW +: AW]));
      chk($sformatf("rrdy%0d", k), rrdy[k], exp_rrdy(ra[k*AW +: AW]));
    end
    chk("busy_any", busy_any, exp_busy_any());
  endtask

  // Inputs are driven at the negedge; compare mid-cycle, then advance the model across the posedge.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    if (we0 && wa0 != 0) begin m_mem[wa0] = wd0; m_busy[wa0] = 1'b0; end
    if (we1 && wa1 != 0) begin m_mem[wa1] = wd1; m_busy[wa1] = 1'b0; end
    if (iss_en && iss_reg != 0) m_busy[iss_reg] = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; iss_en = 0;
    wa0 = '0; wa1 = '0; iss_reg = '0; wd0 = '0; wd1 = '0;
  endtask

  task automatic set_ra(input int a0, input int a1, input int a2);
    ra = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  initial begin
    model_reset();
    #2;
    chk("reset_rd", rd, '0);
    chk("reset_rrdy", rrdy, 3'b111);
    chk("reset_busy_any", busy_any, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write bypass then stored readback.
    idle(); set_ra(5, 0, 0); we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF;
    #1 chk("byp_r5", rd[0 +: DW], 32'hDEADBEEF);
    cycle();
    idle(); set_ra(5, 0, 0);
    #1 chk("stored_r5", rd[0 +: DW], 32'hDEADBEEF);
    cycle();

    // Same-address double write: port 1 wins.
    idle(); set_ra(0, 7, 0); we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22;
    #1 chk("dual_byp_r7", rd[DW +: DW], 32'h22);
    cycle();
    idle(); set_ra(0, 7, 0);
    #1 chk("dual_stored_r7", rd[DW +: DW], 32'h22);
    cycle();

    // Issue r3, then release it by a write four cycles later.
    idle(); set_ra(0, 0, 3); iss_en = 1; iss_reg = 3;
    #1 chk("iss_c0_rrdy2", rrdy[2], 1'b1);
    cycle();
    idle(); set_ra(0, 0, 3);
    #1 chk("iss_c1_rrdy2", rrdy[2], 1'b0);
    chk("iss_c1_busy_any", busy_any, 1'b1);
    cycle();
    cycle();
    cycle();
    we0 = 1; wa0 = 3; wd0 = 32'h333;
    #1 chk("iss_c4_rrdy2", rrdy[2], 1'b1);
    cycle();
    idle(); set_ra(0, 0, 3);
    #1 chk("iss_c5_rrdy2", rrdy[2], 1'b1);
    chk("iss_c5_busy_any", busy_any, 1'b0);
    cycle();

    // Issue and write the same register: set wins, data still stored.
    idle(); set_ra(0, 0, 0); we1 = 1; wa1 = 9; wd1 = 32'h99; iss_en = 1; iss_reg = 9;
    cycle();
    idle(); set_ra(9, 0, 0);
    #1 chk("isswr_r9_data", rd[0 +: DW], 32'h99);
    chk("isswr_r9_rrdy", rrdy[0], 1'b0);
    chk("isswr_busy_any", busy_any, 1'b1);
    cycle();
    idle(); we0 = 1; wa0 = 9; wd0 = 32'h999;
    cycle();

    // Register 0 ignores writes and issues.
    idle(); set_ra(0, 0, 0); we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF; iss_en = 1; iss_reg = 0;
    #1 chk("r0_rd", rd[0 +: DW], 32'h0);
    chk("r0_rrdy", rrdy[0], 1'b1);
    cycle();
    idle();
    #1 chk("r0_busy_any", busy_any, 1'b0);
    chk("r0_rd_after", rd[0 +: DW], 32'h0);
    cycle();

    // Randomized traffic over a narrow address range to force collisions.
    for (int n = 0; n < 300; n++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = AW'($urandom_range(0, 7)); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); wa1 = AW'($urandom_range(0, 7)); wd1 = $urandom;
      iss_en = ($urandom_range(0, 2) == 0); iss_reg = AW'($urandom_range(0, 7));
      set_ra($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
      cycle();
    end

    // Asynchronous reset between edges with r5 busy and holding data.
    idle(); set_ra(0, 0, 0); we0 = 1; wa0 = 5; wd0 = 32'h55; iss_en = 1; iss_reg = 5;
    cycle();
    idle(); set_ra(5, 0, 0);
    #1 chk("pre_rst_r5", rd[0 +: DW], 32'h55);
    chk("pre_rst_rrdy", rrdy[0], 1'b0);
    #1 rst_n = 1'b0;
    #1 chk("async_rst_rd", rd[0 +: DW], 32'h0);
    chk("async_rst_rrdy", rrdy[0], 1'b1);
    chk("async_rst_busy_any", busy_any, 1'b0);
    model_reset();
    // Writes and issues presented while reset is held are discarded.
    we1 = 1; wa1 = 6; wd1 = 32'h66; iss_en = 1; iss_reg = 6;
    @(posedge clk);
    @(negedge clk);
    idle(); set_ra(5, 6, 6);
    #1 chk("rst_hold_r6", rd[DW +: DW], 32'h0);
    chk("rst_hold_rrdy", rrdy, 3'b111);
    rst_n = 1'b1;
    cycle();

    // First edge after reset performs normal writes and issues.
    idle(); we0 = 1; wa0 = 4; wd0 = 32'h44; iss_en = 1; iss_reg = 2;
    cycle();
    idle(); set_ra(4, 2, 0);
    #1 chk("post_rst_r4", rd[0 +: DW], 32'h44);
    chk("post_rst_rrdy_r2", rrdy[1], 1'b0);
    cycle();
    for (int n = 0; n < 50; n++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = AW'($urandom); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); wa1 = AW'($urandom); wd1 = $urandom;
      iss_en = 1'($urandom_range(0, 1)); iss_reg = AW'($urandom);
      ra = NR*AW'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
